serial_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one serial transmitter between NREQ requesters.
- Arbitrates among pending requests and muxes the winner's word onto the transmitter data input.
- Sequences the transmitter's Sample/StartTx controls and watches TxBusy/TxDone to detect completion; a watchdog aborts stalled transfers.
- Sits between the requesting datapath blocks and the serial transmitter, in the transmitter's Clk domain.

---
 rtl/serial_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler.sv
// Round-robin owner selection for a single shared serial transmitter.
// Sequences Sample/StartTx, watches TxBusy/TxDone, and aborts stalled frames.
module serial_tx_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] ReqData,
  output logic [NREQ-1:0]       Grant,
  output logic [NREQ-1:0]       Done,
  output logic                  Err,
  output logic [2:0]            ErrId,
  output logic [WIDTH-1:0]      TxData,
  output logic                  Sample,
  output logic                  StartTx,
  input  logic                  TxBusy,
  input  logic                  TxDone,
  output logic [15:0]           TxCount
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     err_id_q, err_id_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic [15:0]       wd_q, wd_d;

  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     cand;
  int                pos;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan starts just after the previous owner so every waiting requester is reached.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = int'(last_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IW'(pos);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    err_id_d   = err_id_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
    wd_d       = wd_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d     = win;
          tx_data_d = ReqData[int'(win)*WIDTH +: WIDTH];
          grant_d   = onehot(win);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        wd_d    = '0;
        state_d = S_START;
      end
      S_START, S_WAIT: begin
        // TxDone is only trusted in WAIT, i.e. after TxBusy was seen for this frame.
        if (state_q == S_WAIT && TxDone && !TxBusy) begin
          done_d     = onehot(idx_q);
          tx_count_d = tx_count_q + 16'd1;
          last_d     = idx_q;
          grant_d    = '0;
          state_d    = S_DONE;
        end else if (wd_q == WD_LIMIT) begin
          err_d    = 1'b1;
          err_id_d = idx_q;
          last_d   = idx_q;
          grant_d  = '0;
          state_d  = S_IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
          if (state_q == S_START && TxBusy) state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      err_id_q   <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      err_id_q   <= err_id_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_count_q <= tx_count_d;
      wd_q       <= wd_d;
    end
  end

  assign Grant   = grant_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign ErrId   = 3'(err_id_q);
  assign TxData  = tx_data_q;
  assign TxCount = tx_count_q;
  assign Sample  = (state_q == S_LOAD);
  assign StartTx = (state_q == S_START);

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: transaction-level reference model compared every
// cycle, a behavioural transmitter, directed scenarios and randomized traffic.
module tb_serial_tx_scheduler;
  localparam int W = 32;
  localparam int N = 4;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, done;
  logic           err, sample, starttx;
  logic [2:0]     errid;
  logic [W-1:0]   txdata;
  logic [15:0]    txcount;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b1;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  serial_tx_scheduler #(.WIDTH(W), .NREQ(N), .TIMEOUT(T)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .ReqData(req_data),
    .Grant(grant), .Done(done), .Err(err), .ErrId(errid),
    .TxData(txdata), .Sample(sample), .StartTx(starttx),
    .TxBusy(tx_busy), .TxDone(tx_done), .TxCount(txcount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int waited);
    n_vec++;
    n_mis++;
    $display("FAIL %s: waited %0d cycles, expected event never came", name, waited);
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Reference model: who owns the transmitter and how far its transfer has got.
  int            m_own = -1;
  int            m_last = N - 1;
  int            m_wd = 0;
  bit            m_fresh = 0, m_seen = 0, m_fin = 0, m_valid = 0;
  int            preload_req = 0, preload_ack = 0;
  logic [N-1:0]  e_grant = '0, e_done = '0;
  logic          e_err = 0, e_sample = 0, e_start = 0;
  logic [2:0]    e_errid = '0;
  logic [W-1:0]  e_data = '0;
  logic [15:0]   e_cnt = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_own = -1; m_last = N - 1; m_wd = 0;
      m_fresh = 0; m_seen = 0; m_fin = 0;
      e_grant = '0; e_done = '0; e_err = 0; e_errid = '0;
      e_data = '0; e_cnt = '0; e_sample = 0; e_start = 0;
    end else if (m_valid) begin
      if (preload_req != preload_ack) begin
        e_cnt = 16'hFFFF;
        preload_ack = preload_req;
      end
      e_done = '0;
      e_err  = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_own < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_own < 0 && req[(m_last + k) % N]) m_own = (m_last + k) % N;
        end
        if (m_own >= 0) begin
          e_grant = '0;
          e_grant[m_own] = 1'b1;
          e_data = req_data[m_own*W +: W];
          e_sample = 1;
          m_fresh = 1;
        end
      end else if (m_fresh) begin
        m_fresh = 0; e_sample = 0; e_start = 1; m_wd = 0; m_seen = 0;
      end else begin
        if (m_seen && tx_done && !tx_busy) begin
          e_done = '0;
          e_done[m_own] = 1'b1;
          e_grant = '0;
          e_cnt = e_cnt + 16'd1;
          m_last = m_own; m_own = -1; m_fin = 1;
        end else if (m_wd == T - 1) begin
          e_err = 1; e_errid = 3'(m_own); e_grant = '0; e_start = 0;
          m_last = m_own; m_own = -1;
        end else begin
          m_wd++;
          if (!m_seen && tx_busy) begin
            m_seen = 1; e_start = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("Grant",   grant,   e_grant);
      chk("Done",    done,    e_done);
      chk("Err",     err,     e_err);
      chk("ErrId",   errid,   e_errid);
      chk("TxData",  txdata,  e_data);
      chk("Sample",  sample,  e_sample);
      chk("StartTx", starttx, e_start);
      chk("TxCount", txcount, e_cnt);
    end
  end

  // Transmitter: optional latency after StartTx, busy for a frame, then TxDone level.
  bit tx_never = 0, tx_rand = 0;
  int tx_lat_fix = 0, tx_len_fix = 5;
  int tx_ph = 0, tx_left = 0, tx_cur_lat = 0, tx_cur_len = 0;

  always @(negedge clk) begin
    case (tx_ph)
      0: if (starttx === 1'b1 && !tx_never) begin
        if (tx_rand) begin
          tx_cur_lat = $urandom_range(0, 3);
          tx_cur_len = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 40);
        end else begin
          tx_cur_lat = tx_lat_fix;
          tx_cur_len = tx_len_fix;
        end
        if (tx_cur_lat == 0) begin
          tx_busy = 1; tx_done = 0; tx_left = tx_cur_len; tx_ph = 2;
        end else begin
          tx_left = tx_cur_lat; tx_ph = 1;
        end
      end
      1: begin
        tx_left--;
        if (tx_left == 0) begin
          tx_busy = 1; tx_done = 0; tx_left = tx_cur_len; tx_ph = 2;
        end
      end
      default: begin
        tx_left--;
        if (tx_left == 0) begin
          tx_busy = 0; tx_done = 1; tx_ph = 0;
        end
      end
    endcase
  end

  int order[$];

  task automatic xfer(input logic [N-1:0] r, output int cyc, output logic [N-1:0] dn,
                      output logic er, output logic [2:0] eid);
    int guard;
    req = r; cyc = -1; dn = '0; er = 0; eid = '0; guard = 0;
    while (starttx !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      bound_fail("xfer_start", guard);
      return;
    end
    cyc = 0;
    while (done == '0 && err !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) begin
      bound_fail("xfer_end", cyc);
      return;
    end
    dn = done; er = err; eid = errid;
    req = req & ~done;
    if (err) req[errid[1:0]] = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    int guard;
    guard = 0;
    while (grant == '0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) bound_fail(name, guard);
  endtask

  task automatic collect(input int n);
    int got, guard;
    logic [N-1:0] pg;
    got = 0; guard = 0; pg = grant;
    while (got < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (grant != '0 && pg == '0) order.push_back(idx_of(grant));
      pg = grant;
      if (done != '0) got++;
    end
    if (guard >= 2000) bound_fail("rr_collect", guard);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] dn;
    logic er;
    logic [2:0] eid;
    int exp_ord[7];

    rst = 1; req = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_grant", grant, 0);
    chk("rst_count", txcount, 0);
    chk("rst_txdata", txdata, 0);
    chk("rst_sample_start", {sample, starttx, err}, 0);

    // Round robin: 1111 held for four transfers, then 1010 for three.
    tx_lat_fix = 0; tx_len_fix = 5;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1000_0000 + i;
    req = 4'b1111;
    collect(4);
    req = 4'b1010;
    collect(3);
    req = '0;
    exp_ord = '{0, 1, 2, 3, 1, 3, 1};
    chk("rr_len", order.size(), 7);
    for (int i = 0; i < 7; i++) if (i < order.size()) chk("rr_order", order[i], exp_ord[i]);
    chk("rr_count", txcount, 7);
    repeat (3) @(negedge clk);

    // Single requester, 40-cycle frame, stale TxDone high when StartTx begins.
    tx_lat_fix = 1; tx_len_fix = 40;
    req_data[0 +: W] = 32'hA5A5_0F0F;
    req = 4'b0001;
    wait_grant("single_grant");
    chk("single_sample", sample, 1);
    chk("single_start_lo", starttx, 0);
    chk("single_txdata", txdata, 32'hA5A5_0F0F);
    req_data[0 +: W] = 32'hDEAD_BEEF;
    xfer(4'b0001, cyc, dn, er, eid);
    chk("single_latency", cyc, 42);
    chk("single_done", dn, 4'b0001);
    chk("single_count", txcount, 8);
    chk("single_txdata_held", txdata, 32'hA5A5_0F0F);

    // Watchdog: transmitter never answers; requester 3 is served next.
    repeat (3) @(negedge clk);
    tx_never = 1; tx_lat_fix = 0; tx_len_fix = 5;
    xfer(4'b1100, cyc, dn, er, eid);
    tx_never = 0;
    chk("to_latency", cyc, T);
    chk("to_err", er, 1);
    chk("to_errid", eid, 2);
    chk("to_no_done", dn, 0);
    chk("to_count", txcount, 8);
    wait_grant("to_next_grant");
    chk("to_next_owner", grant, 4'b1000);
    xfer(4'b1000, cyc, dn, er, eid);
    chk("to_next_done", dn, 4'b1000);

    // Completion on the last watchdog cycle wins; one cycle later it aborts.
    repeat (3) @(negedge clk);
    tx_lat_fix = 0; tx_len_fix = T - 1;
    xfer(4'b0001, cyc, dn, er, eid);
    chk("edge_done", dn, 4'b0001);
    chk("edge_no_err", er, 0);
    chk("edge_latency", cyc, T);
    repeat (3) @(negedge clk);
    tx_len_fix = T;
    xfer(4'b0001, cyc, dn, er, eid);
    chk("late_err", er, 1);
    chk("late_no_done", dn, 0);
    chk("late_latency", cyc, T);

    // Reset in the middle of WAIT.
    repeat (80) @(negedge clk);
    tx_len_fix = 30;
    req = 4'b0100;
    wait_grant("rst_mid_grant");
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid_grant", grant, 0);
    chk("rstmid_count", txcount, 0);
    chk("rstmid_txdata", txdata, 0);
    chk("rstmid_pulses", {done, err, sample, starttx}, 0);
    req = 4'b1111;
    wait_grant("rstmid_regrant");
    chk("rstmid_owner", grant, 4'b0001);
    xfer(4'b0001, cyc, dn, er, eid);
    chk("rstmid_done", dn, 4'b0001);
    req = '0;

    // Counter wrap.
    repeat (60) @(negedge clk);
    #2;
    force dut.tx_count_q = 16'hFFFF;
    preload_req++;
    @(posedge clk);
    #2;
    release dut.tx_count_q;
    @(negedge clk);
    chk("wrap_preload", txcount, 16'hFFFF);
    tx_len_fix = 3;
    xfer(4'b0010, cyc, dn, er, eid);
    chk("wrap_done", dn, 4'b0010);
    chk("wrap_count", txcount, 0);

    // Randomized traffic against the model.
    tx_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && (done[i] || (err && errid == 3'(i)))) req[i] = 1'b0;
        else if (req[i] && grant[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
        else if (!req[i] && !grant[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = $urandom;
        end
        if (grant[i] && $urandom_range(0, 3) == 0) req_data[i*W +: W] = $urandom;
      end
    end
    req = '0;
    repeat (200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
